// File: rtl/argmax_stream.sv
// Streaming argmax/argmin: a registered binary comparator tree reduces each
// LANES-wide beat, and an accumulator keeps the running best across the beats
// of a vector. It emits the winning global index and value once per vector.
module argmax_stream #(
    parameter int unsigned LANES     = 200,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned IDX_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    in_mode,
    input  logic [LANES*DATA_W-1:0] d,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic [DATA_W-1:0]       out_val,
    output logic                    out_err
);

    localparam int unsigned L      = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned HALF   = (LANES + 1) / 2;
    localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);

    // Number of live nodes at tree level k (level 0 is the raw beat).
    function automatic int unsigned node_cnt(input int unsigned k);
        return (LANES + (32'd1 << k) - 32'd1) >> k;
    endfunction

    // True when r strictly beats l under the given mode (0 = max, 1 = min).
    function automatic logic pick_right(input logic mode,
                                        input logic signed [DATA_W-1:0] l,
                                        input logic signed [DATA_W-1:0] r);
        return mode ? (r < l) : (r > l);
    endfunction

    logic signed [DATA_W-1:0] tree_val;
    logic [LIDX_W-1:0]        tree_idx;
    logic                     tree_v;
    logic                     tree_last;
    logic                     tree_mode;

    if (L == 0) begin : g_no_tree
        // A single lane needs no reduction; the beat feeds the accumulator.
        assign tree_val  = d[DATA_W-1:0];
        assign tree_idx  = '0;
        assign tree_v    = in_valid & run;
        assign tree_last = in_last;
        assign tree_mode = in_mode;
    end else begin : g_tree
        // One spare slot so the right-neighbour select never leaves the array.
        logic signed [DATA_W-1:0] lvl_val  [0:L][0:LANES];
        logic [LIDX_W-1:0]        lvl_idx  [0:L][0:LANES];
        logic                     lvl_v    [0:L];
        logic                     lvl_last [0:L];
        logic                     lvl_mode [0:L];

        logic signed [DATA_W-1:0] nxt_val  [1:L][0:HALF-1];
        logic [LIDX_W-1:0]        nxt_idx  [1:L][0:HALF-1];
        logic signed [DATA_W-1:0] stg_val  [1:L][0:HALF-1];
        logic [LIDX_W-1:0]        stg_idx  [1:L][0:HALF-1];
        logic                     stg_v    [1:L];
        logic                     stg_last [1:L];
        logic                     stg_mode [1:L];

        // Uniform view of every level: level 0 is the input beat, level k the k-th stage.
        always_comb begin
            for (int unsigned k = 0; k <= L; k++) begin
                lvl_v[k]    = 1'b0;
                lvl_last[k] = 1'b0;
                lvl_mode[k] = 1'b0;
                for (int unsigned j = 0; j <= LANES; j++) begin
                    lvl_val[k][j] = '0;
                    lvl_idx[k][j] = '0;
                end
            end
            for (int unsigned j = 0; j < LANES; j++) begin
                lvl_val[0][j] = d[j*DATA_W +: DATA_W];
                lvl_idx[0][j] = LIDX_W'(j);
            end
            lvl_v[0]    = in_valid & run;
            lvl_last[0] = in_last;
            lvl_mode[0] = in_mode;
            for (int unsigned k = 1; k <= L; k++) begin
                for (int unsigned j = 0; j < HALF; j++) begin
                    lvl_val[k][j] = stg_val[k][j];
                    lvl_idx[k][j] = stg_idx[k][j];
                end
                lvl_v[k]    = stg_v[k];
                lvl_last[k] = stg_last[k];
                lvl_mode[k] = stg_mode[k];
            end
        end

        // Pair neighbours; an odd leftover passes through; ties keep the lower lane.
        always_comb begin
            for (int unsigned k = 1; k <= L; k++) begin
                for (int unsigned j = 0; j < HALF; j++) begin
                    nxt_val[k][j] = '0;
                    nxt_idx[k][j] = '0;
                    if (j < node_cnt(k)) begin
                        if ((2*j + 1 < node_cnt(k - 1)) &&
                            pick_right(lvl_mode[k-1], lvl_val[k-1][2*j], lvl_val[k-1][2*j+1])) begin
                            nxt_val[k][j] = lvl_val[k-1][2*j+1];
                            nxt_idx[k][j] = lvl_idx[k-1][2*j+1];
                        end else begin
                            nxt_val[k][j] = lvl_val[k-1][2*j];
                            nxt_idx[k][j] = lvl_idx[k-1][2*j];
                        end
                    end
                end
            end
        end

        // Stage control bits; dropping run flushes every in-flight beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 1; k <= L; k++) begin
                    stg_v[k]    <= 1'b0;
                    stg_last[k] <= 1'b0;
                    stg_mode[k] <= 1'b0;
                end
            end else begin
                for (int unsigned k = 1; k <= L; k++) begin
                    stg_v[k]    <= run & lvl_v[k-1];
                    stg_last[k] <= lvl_last[k-1];
                    stg_mode[k] <= lvl_mode[k-1];
                end
            end
        end

        // Stage payload, qualified by the stage valid bit.
        always_ff @(posedge clk) begin
            for (int unsigned k = 1; k <= L; k++) begin
                for (int unsigned j = 0; j < HALF; j++) begin
                    stg_val[k][j] <= nxt_val[k][j];
                    stg_idx[k][j] <= nxt_idx[k][j];
                end
            end
        end

        assign tree_val  = lvl_val[L][0];
        assign tree_idx  = lvl_idx[L][0];
        assign tree_v    = lvl_v[L];
        assign tree_last = lvl_last[L];
        assign tree_mode = lvl_mode[L];
    end

    typedef enum logic {ST_FIRST, ST_ACC} state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic                     mode_q, mode_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     out_valid_d;
    logic [IDX_W-1:0]         out_idx_d;
    logic [DATA_W-1:0]        out_val_d;
    logic                     out_err_d;
    logic [IDX_W-1:0]         gidx;

    // Accumulator next state: first beat seeds the best, later beats need a strict win.
    always_comb begin
        state_d     = state_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx;
        out_val_d   = out_val;
        out_err_d   = out_err;
        gidx        = IDX_W'(cnt_q) * IDX_W'(LANES) + IDX_W'(tree_idx);

        if (!run) begin
            state_d = ST_FIRST;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (tree_v) begin
            case (state_q)
                ST_FIRST: begin
                    best_val_d = tree_val;
                    best_idx_d = IDX_W'(tree_idx);
                    mode_d     = tree_mode;
                    cnt_d      = CNT_W'(1);
                    ovf_d      = 1'b0;
                    state_d    = ST_ACC;
                end
                ST_ACC: begin
                    if (cnt_q < CNT_W'(MAX_BEATS)) begin
                        if (pick_right(mode_q, best_val_q, tree_val)) begin
                            best_val_d = tree_val;
                            best_idx_d = gidx;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = ST_FIRST;
            endcase
            if (tree_last) begin
                out_valid_d = 1'b1;
                out_idx_d   = best_idx_d;
                out_val_d   = best_val_d;
                out_err_d   = ovf_d;
                state_d     = ST_FIRST;
            end
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FIRST;
            best_val_q <= '0;
            best_idx_q <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_val    <= '0;
            out_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_valid  <= out_valid_d;
            out_idx    <= out_idx_d;
            out_val    <= out_val_d;
            out_err    <= out_err_d;
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Randomised bench for argmax_stream: a 200-lane and a 5-lane instance share
// stimulus and are checked against a flat-scan reference model.
module tb_argmax_stream;

    localparam int unsigned LANES     = 200;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned IDX_W     = 10;
    localparam int unsigned LANES_S   = 5;
    localparam int unsigned IDX_W_S   = 5;
    localparam int          LAT       = 9;   // ceil(log2(200)) + 1
    localparam int          LAT_S     = 4;   // ceil(log2(5)) + 1

    typedef struct {
        int cyc;
        int idx;
        int val;
        bit err;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    run;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_mode;
    logic [LANES*DATA_W-1:0] d;
    logic                    out_valid, out_valid_s;
    logic [IDX_W-1:0]        out_idx;
    logic [IDX_W_S-1:0]      out_idx_s;
    logic [DATA_W-1:0]       out_val, out_val_s;
    logic                    out_err, out_err_s;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cur [0:LANES-1];
    int   vec [0:7][0:LANES-1];
    int   nbeats = 0;
    bit   vmode = 1'b0;
    exp_t exp_q[$];
    exp_t exp_s[$];
    int   last_idx = 0, last_val = 0, last_idx_s = 0, last_val_s = 0;

    argmax_stream #(.LANES(LANES), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .IDX_W(IDX_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .in_valid(in_valid), .in_last(in_last),
        .in_mode(in_mode), .d(d), .out_valid(out_valid), .out_idx(out_idx),
        .out_val(out_val), .out_err(out_err)
    );

    argmax_stream #(.LANES(LANES_S), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .IDX_W(IDX_W_S)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .run(run), .in_valid(in_valid), .in_last(in_last),
        .in_mode(in_mode), .d(d[LANES_S*DATA_W-1:0]), .out_valid(out_valid_s), .out_idx(out_idx_s),
        .out_val(out_val_s), .out_err(out_err_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: scan beats/lanes in global index order, replace only on a strict win.
    function automatic void ref_result(input int lanes, output int ridx, output int rval, output bit rerr);
        int nb;
        int v;
        nb   = (nbeats > MAX_BEATS) ? MAX_BEATS : nbeats;
        ridx = 0;
        rval = vec[0][0];
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < lanes; i++) begin
                v = vec[b][i];
                if (vmode ? (v < rval) : (v > rval)) begin
                    rval = v;
                    ridx = b * lanes + i;
                end
            end
        end
        rerr = (nbeats > MAX_BEATS);
    endfunction

    task automatic fill(input int lo, input int hi);
        for (int i = 0; i < LANES; i++) cur[i] = lo + int'($urandom_range(0, hi - lo));
    endtask

    task automatic fill_full();
        for (int i = 0; i < LANES; i++) cur[i] = $signed(16'($urandom()));
    endtask

    // Drive one valid beat from cur[] and record it in the model.
    task automatic send(input bit last, input bit mode);
        exp_t e;
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = 16'(cur[i]);
        in_valid = 1'b1;
        in_last  = last;
        in_mode  = mode;
        if (nbeats == 0) vmode = mode;
        if (nbeats < 8) begin
            for (int i = 0; i < LANES; i++) vec[nbeats][i] = cur[i];
        end
        nbeats++;
        if (last) begin
            ref_result(LANES, e.idx, e.val, e.err);
            e.cyc = cyc + LAT;
            exp_q.push_back(e);
            ref_result(LANES_S, e.idx, e.val, e.err);
            e.cyc = cyc + LAT_S;
            exp_s.push_back(e);
            nbeats = 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            d = {LANES*DATA_W/32{$urandom()}};
            @(posedge clk);
            #1;
        end
    endtask

    // Result monitor for the 200-lane instance.
    always @(negedge clk) begin : mon_main
        exp_t e;
        bit   ev;
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (rst_n && (out_valid || ev)) begin
            check_eq("out_valid", int'(out_valid), int'(ev));
            if (ev) begin
                e = exp_q.pop_front();
                check_eq("out_idx", int'(out_idx), e.idx);
                check_eq("out_val", int'($signed(out_val)), e.val);
                check_eq("out_err", int'(out_err), int'(e.err));
                last_idx = e.idx;
                last_val = e.val;
            end
        end
    end

    // Result monitor for the 5-lane instance.
    always @(negedge clk) begin : mon_small
        exp_t e;
        bit   ev;
        ev = (exp_s.size() > 0) && (exp_s[0].cyc == cyc);
        if (rst_n && (out_valid_s || ev)) begin
            check_eq("s_out_valid", int'(out_valid_s), int'(ev));
            if (ev) begin
                e = exp_s.pop_front();
                check_eq("s_out_idx", int'(out_idx_s), e.idx);
                check_eq("s_out_val", int'($signed(out_val_s)), e.val);
                check_eq("s_out_err", int'(out_err_s), int'(e.err));
                last_idx_s = e.idx;
                last_val_s = e.val;
            end
        end
    end

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, int'(out_valid), 0);
        check_eq({tag, "_idx"}, int'(out_idx), 0);
        check_eq({tag, "_val"}, int'(out_val), 0);
        check_eq({tag, "_err"}, int'(out_err), 0);
        check_eq({tag, "_s_valid"}, int'(out_valid_s), 0);
        check_eq({tag, "_s_idx"}, int'(out_idx_s), 0);
        check_eq({tag, "_s_val"}, int'(out_val_s), 0);
    endtask

    initial begin
        int  nb;
        bit  m;
        int  kind;

        rst_n    = 1'b0;
        run      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_mode  = 1'b0;
        d        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        run   = 1'b1;
        idle(2);

        // Single beat, ramp with one 0x7FFF peak.
        for (int i = 0; i < LANES; i++) cur[i] = i;
        cur[137] = 32767;
        send(1'b1, 1'b0);

        // Signed min with a tie between lanes 5 and 60.
        for (int i = 0; i < LANES; i++) cur[i] = 0;
        cur[5]  = -3;
        cur[60] = -3;
        send(1'b1, 1'b1);

        // Three beats; equal maxima in beats 1 and 2 keep the earlier beat.
        fill(-50, 50);
        send(1'b0, 1'b0);
        fill(-50, 50);
        cur[10] = 100;
        send(1'b0, 1'b0);
        fill(-50, 50);
        cur[0] = 100;
        send(1'b1, 1'b0);

        // Back-to-back single-beat vectors with alternating modes.
        fill(-50, 50);
        cur[3] = 500;
        send(1'b1, 1'b0);
        fill(-50, 50);
        cur[199] = -500;
        send(1'b1, 1'b1);
        fill(-50, 50);
        cur[0] = 500;
        send(1'b1, 1'b0);

        // Five beats: the peak in beat 4 is past MAX_BEATS and must be ignored.
        for (int b = 0; b < 5; b++) begin
            fill(-100, 100);
            if (b == 4) begin
                cur[7] = 30000;
                cur[2] = 30000;
            end
            send(b == 4, 1'b0);
        end
        fill(-100, 100);
        send(1'b0, 1'b1);
        fill(-100, 100);
        send(1'b1, 1'b1);
        idle(LAT + 3);

        // Drop run mid-vector; a valid beat while run is low must be ignored.
        fill(-100, 100);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        idle(LAT + 2);
        run      = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        nbeats = 0;
        run    = 1'b1;
        idle(LAT + 3);
        check_eq("hold_idx", int'(out_idx), last_idx);
        check_eq("hold_val", int'($signed(out_val)), last_val);
        check_eq("hold_s_idx", int'(out_idx_s), last_idx_s);
        check_eq("hold_s_val", int'($signed(out_val_s)), last_val_s);
        fill(-100, 100);
        send(1'b0, 1'b1);
        fill(-100, 100);
        send(1'b1, 1'b1);
        idle(LAT + 3);

        // Async reset with a partial vector in flight.
        fill_full();
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        nbeats     = 0;
        last_idx   = 0;
        last_val   = 0;
        last_idx_s = 0;
        last_val_s = 0;
        idle(LAT + 3);
        fill_full();
        send(1'b0, 1'b0);
        fill_full();
        send(1'b1, 1'b0);

        // Random vectors: mixed lengths, modes, bubbles and tie-heavy data.
        for (int v = 0; v < 60; v++) begin
            nb   = int'($urandom_range(1, 6));
            m    = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            for (int b = 0; b < nb; b++) begin
                if (kind == 0) fill(-8, 7);
                else fill_full();
                if (kind == 2) begin
                    cur[$urandom_range(0, LANES - 1)] = 32767;
                    cur[$urandom_range(0, LANES - 1)] = -32768;
                end
                send(b == nb - 1, m);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end

        idle(LAT + 5);
        check_eq("drain", exp_q.size(), 0);
        check_eq("drain_s", exp_s.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
